// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared widths and the packed write-back FIFO entry.
// Rev    : 1.0
// ============================================================================
package regfile_pkg;

  localparam int DW    = 8;
  localparam int COUNT = 3;
  localparam int AW    = COUNT - 1;
  localparam int NREG  = 1 << AW;

  localparam logic [COUNT-1:0] COUT_ADDR = 3'b111;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] dst;
    logic [DW-1:0] data;
    logic          cout_we;
    logic [DW-1:0] cout;
  } wb_entry_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// ============================================================================
// Module : wb_fifo2
// Brief  : Two-entry in-order FIFO of ALU write-back entries.
// Rev    : 1.0
// ============================================================================
module wb_fifo2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  wb_entry_t  din,
  input  logic       pop,
  output wb_entry_t  head,
  output wb_entry_t  second,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  wb_entry_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // second is only meaningful when count == 2
  assign head   = r_mem[r_rd_ptr];
  assign second = r_mem[~r_rd_ptr];
  assign count  = r_count;
  assign full   = (r_count == 2'd2);
  assign empty  = (r_count == 2'd0);

endmodule : wb_fifo2
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module : reg_writeback
// Brief  : Arbitrates unbuffered loads and FIFO-buffered ALU results onto the
//          register file write port with registered outputs.
// Rev    : 1.0
// ============================================================================
module reg_writeback
  import regfile_pkg::*;
#(
  parameter int COUNT = regfile_pkg::COUNT,
  parameter int DW    = regfile_pkg::DW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic                      alu_wr,
  input  logic [COUNT-2:0]          alu_dst,
  input  logic [DW-1:0]             alu_data,
  input  logic                      alu_cout_we,
  input  logic [DW-1:0]             alu_cout,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [COUNT-2:0]          ld_dst,
  input  logic [DW-1:0]             ld_data,
  output logic                      rf_we,
  output logic [COUNT-2:0]          rf_waddr,
  output logic [DW-1:0]             rf_wdata,
  output logic                      rf_cout_we,
  output logic [DW-1:0]             rf_cout_data,
  output logic [(2**(COUNT-1))-1:0] pending
);

  localparam int c_aw   = COUNT - 1;
  localparam int c_nreg = 2 ** c_aw;

  wb_entry_t         w_alu_entry;
  wb_entry_t         w_head;
  wb_entry_t         w_second;
  wb_entry_t         w_present;
  logic [1:0]        w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_ld_fire;
  logic              w_alu_fire;
  logic              w_alu_useful;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic              w_present_alu;
  logic [c_nreg-1:0] w_pending;

  logic              r_rf_we;
  logic [c_aw-1:0]   r_rf_waddr;
  logic [DW-1:0]     r_rf_wdata;
  logic              r_rf_cout_we;
  logic [DW-1:0]     r_rf_cout_data;

  wb_fifo2 u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_push),
    .din    (w_alu_entry),
    .pop    (w_pop),
    .head   (w_head),
    .second (w_second),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // A register is pending exactly while a queued ALU entry still targets it;
  // loads and bypassed results are presented at their acceptance edge.
  for (genvar i = 0; i < c_nreg; i++) begin : g_pending
    assign w_pending[i] =
        (!w_empty && w_head.wr && (w_head.dst == c_aw'(i))) ||
        ((w_count == 2'd2) && w_second.wr && (w_second.dst == c_aw'(i)));
  end

  assign pending   = w_pending;
  assign alu_ready = !w_full;
  assign ld_ready  = !w_pending[ld_dst];

  always_comb begin
    w_alu_entry         = '0;
    w_alu_entry.wr      = alu_wr;
    w_alu_entry.dst     = alu_dst;
    w_alu_entry.data    = alu_data;
    w_alu_entry.cout_we = alu_cout_we;
    w_alu_entry.cout    = alu_cout;

    w_ld_fire     = ld_valid && ld_ready;
    w_alu_fire    = alu_valid && alu_ready;
    // Entries that write nothing are accepted but never stored or presented.
    w_alu_useful  = alu_wr || alu_cout_we;
    w_pop         = !w_ld_fire && !w_empty;
    w_bypass      = !w_ld_fire && w_empty && w_alu_fire && w_alu_useful;
    w_push        = w_alu_fire && w_alu_useful && !w_bypass;
    w_present_alu = w_pop || w_bypass;
    w_present     = w_bypass ? w_alu_entry : w_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= '0;
      r_rf_wdata     <= '0;
      r_rf_cout_we   <= 1'b0;
      r_rf_cout_data <= '0;
    end else if (w_ld_fire) begin
      r_rf_we      <= 1'b1;
      r_rf_waddr   <= ld_dst;
      r_rf_wdata   <= ld_data;
      r_rf_cout_we <= 1'b0;
    end else if (w_present_alu) begin
      r_rf_we      <= w_present.wr;
      r_rf_cout_we <= w_present.cout_we;
      if (w_present.wr) begin
        r_rf_waddr <= w_present.dst;
        r_rf_wdata <= w_present.data;
      end
      if (w_present.cout_we) begin
        r_rf_cout_data <= w_present.cout;
      end
    end else begin
      r_rf_we      <= 1'b0;
      r_rf_cout_we <= 1'b0;
    end
  end

  assign rf_we        = r_rf_we;
  assign rf_waddr     = r_rf_waddr;
  assign rf_wdata     = r_rf_wdata;
  assign rf_cout_we   = r_rf_cout_we;
  assign rf_cout_data = r_rf_cout_data;

endmodule : reg_writeback
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_writeback
// Brief  : Directed and random stimulus against a queue-based reference model.
// Rev    : 1.0
// ============================================================================
module tb_reg_writeback;

  typedef struct packed {
    logic       wr;
    logic [1:0] dst;
    logic [7:0] data;
    logic       cwe;
    logic [7:0] cout;
  } tb_ent_t;

  logic       clk;
  logic       rst_n;
  logic       alu_valid;
  logic       alu_ready;
  logic       alu_wr;
  logic [1:0] alu_dst;
  logic [7:0] alu_data;
  logic       alu_cout_we;
  logic [7:0] alu_cout;
  logic       ld_valid;
  logic       ld_ready;
  logic [1:0] ld_dst;
  logic [7:0] ld_data;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       rf_cout_we;
  logic [7:0] rf_cout_data;
  logic [3:0] pending;

  int unsigned n_total;
  int unsigned n_bad;

  // Reference model: queue of buffered ALU results plus expected rf_* values.
  tb_ent_t    q[$];
  logic       e_we;
  logic [1:0] e_waddr;
  logic [7:0] e_wdata;
  logic       e_cwe;
  logic [7:0] e_cdata;
  logic       last_ld_rdy;
  logic       last_alu_rdy;

  reg_writeback #(.COUNT(3), .DW(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_wr       (alu_wr),
    .alu_dst      (alu_dst),
    .alu_data     (alu_data),
    .alu_cout_we  (alu_cout_we),
    .alu_cout     (alu_cout),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_dst       (ld_dst),
    .ld_data      (ld_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rf_cout_we   (rf_cout_we),
    .rf_cout_data (rf_cout_data),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_pend();
    logic [3:0] p;
    p = '0;
    foreach (q[i]) if (q[i].wr) p[q[i].dst] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    q.delete();
    e_we = 1'b0; e_waddr = '0; e_wdata = '0; e_cwe = 1'b0; e_cdata = '0;
  endtask

  task automatic present(input tb_ent_t e);
    e_we  = e.wr;
    e_cwe = e.cwe;
    if (e.wr) begin e_waddr = e.dst; e_wdata = e.data; end
    if (e.cwe) e_cdata = e.cout;
  endtask

  task automatic check_outputs(input string pfx);
    logic [3:0] mp;
    mp = model_pend();
    check({pfx, "_we"},    rf_we,        e_we);
    check({pfx, "_waddr"}, rf_waddr,     e_waddr);
    check({pfx, "_wdata"}, rf_wdata,     e_wdata);
    check({pfx, "_cwe"},   rf_cout_we,   e_cwe);
    check({pfx, "_cdata"}, rf_cout_data, e_cdata);
    check({pfx, "_pend"},  pending,      mp);
  endtask

  task automatic step(input bit lv, input logic [1:0] ld, input logic [7:0] ldat,
                      input bit av, input bit aw, input logic [1:0] ad,
                      input logic [7:0] adat, input bit acw, input logic [7:0] acout);
    bit         m_ldr, m_alur, ldf, alf;
    logic [3:0] mp;
    tb_ent_t    e;
    @(negedge clk);
    ld_valid = lv; ld_dst = ld; ld_data = ldat;
    alu_valid = av; alu_wr = aw; alu_dst = ad; alu_data = adat;
    alu_cout_we = acw; alu_cout = acout;
    #1;
    mp     = model_pend();
    m_alur = (q.size() < 2);
    m_ldr  = !mp[ld];
    last_ld_rdy  = ld_ready;
    last_alu_rdy = alu_ready;
    check("alu_ready", alu_ready, m_alur);
    check("ld_ready",  ld_ready,  m_ldr);
    ldf = lv && m_ldr;
    alf = av && m_alur && (aw || acw);
    e.wr = aw; e.dst = ad; e.data = adat; e.cwe = acw; e.cout = acout;
    @(posedge clk);
    if (ldf) begin
      e_we = 1'b1; e_waddr = ld; e_wdata = ldat; e_cwe = 1'b0;
      if (alf) q.push_back(e);
    end else if (q.size() > 0) begin
      present(q.pop_front());
      if (alf) q.push_back(e);
    end else if (alf) begin
      present(e);
    end else begin
      e_we = 1'b0; e_cwe = 1'b0;
    end
    #1;
    check_outputs("out");
  endtask

  task automatic idle();
    step(0, 2'd0, 8'h00, 0, 0, 2'd0, 8'h00, 0, 8'h00);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1;
    model_clear();
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    rst_n = 1'b0;
    ld_valid = 0; ld_dst = 0; ld_data = 0;
    alu_valid = 0; alu_wr = 0; alu_dst = 0; alu_data = 0; alu_cout_we = 0; alu_cout = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset_alu_rdy", alu_ready, 1);
    check("reset_ld_rdy",  ld_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass of a full R-type result into an empty FIFO
    step(0, 2'd0, 8'h00, 1, 1, 2'd2, 8'h5A, 1, 8'h01);
    check("r37_we", rf_we, 1);       check("r37_waddr", rf_waddr, 2);
    check("r37_wdata", rf_wdata, 8'h5A);
    check("r37_cwe", rf_cout_we, 1); check("r37_cdata", rf_cout_data, 8'h01);

    // Load and ALU to the same register in one cycle
    step(1, 2'd1, 8'h33, 1, 1, 2'd1, 8'h44, 0, 8'h00);
    check("r38_first", rf_wdata, 8'h33);
    check("r38_pend_set", pending[1], 1);
    idle();
    check("r38_second", rf_wdata, 8'h44);
    check("r38_waddr", rf_waddr, 1);
    check("r38_pend_clr", pending[1], 0);

    // Loads starve the ALU: FIFO fills after two accepts
    step(1, 2'd0, 8'h10, 1, 1, 2'd1, 8'hA1, 0, 8'h00);
    step(1, 2'd0, 8'h11, 1, 1, 2'd2, 8'hA2, 0, 8'h00);
    step(1, 2'd0, 8'h12, 1, 1, 2'd3, 8'hA3, 0, 8'h00);
    check("r39_rdy_low", last_alu_rdy, 0);
    step(1, 2'd0, 8'h13, 1, 1, 2'd3, 8'hA3, 0, 8'h00);
    check("r39_ld_last", rf_wdata, 8'h13);
    step(0, 2'd0, 8'h00, 1, 1, 2'd3, 8'hA3, 0, 8'h00);
    check("r39_q1", rf_wdata, 8'hA1);
    step(0, 2'd0, 8'h00, 1, 1, 2'd3, 8'hA3, 0, 8'h00);
    check("r39_q2", rf_wdata, 8'hA2);
    idle();
    check("r39_q3", rf_wdata, 8'hA3);

    // Load to a register with a queued ALU write is held off
    step(1, 2'd0, 8'h20, 1, 1, 2'd3, 8'hB3, 0, 8'h00);
    step(1, 2'd3, 8'h21, 0, 0, 2'd0, 8'h00, 0, 8'h00);
    check("r40_blocked", last_ld_rdy, 0);
    check("r40_alu_wr", rf_wdata, 8'hB3);
    step(1, 2'd3, 8'h21, 0, 0, 2'd0, 8'h00, 0, 8'h00);
    check("r40_released", last_ld_rdy, 1);
    check("r40_ld_wr", rf_wdata, 8'h21);

    // Cout-only and empty ALU entries
    step(0, 2'd0, 8'h00, 1, 0, 2'd1, 8'hEE, 1, 8'h77);
    check("cout_only_we", rf_we, 0);
    check("cout_only_cwe", rf_cout_we, 1);
    step(0, 2'd0, 8'h00, 1, 0, 2'd1, 8'hEE, 0, 8'h99);
    check("drop_cwe", rf_cout_we, 0);

    // Reset with two queued entries
    step(1, 2'd0, 8'h30, 1, 1, 2'd1, 8'hC1, 1, 8'hC0);
    step(1, 2'd0, 8'h31, 1, 1, 2'd2, 8'hC2, 0, 8'h00);
    reset_mid();
    repeat (3) idle();
    check("r41_no_stale", rf_we, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_mid();
      end else begin
        step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 8'($urandom),
             $urandom_range(0, 9) < 6, $urandom_range(0, 7) != 0,
             2'($urandom_range(0, 3)), 8'($urandom),
             $urandom_range(0, 1) == 1, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_reg_writeback
`default_nettype wire
